// File: rtl/shifter_serial.sv
// shifter_serial
//   Multi-cycle shift unit: one bit position per clock, behind valid/ready
//   request and result ports. Results match the single-cycle LL/RL/RA
//   shifters bit for bit, including "shift amount >= N gives zero" (RA too).
//
// Parameters
//   N   data width
//   SW  shift-amount width (must be able to hold N)
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   i_valid  request valid (ignored outside IDLE)
//   i_ready  request can be accepted (IDLE and not in reset)
//   i_op     00 LL, 01 RL, 10 RA, 11 pass-through
//   i_a      operand
//   i_s      unsigned shift amount
//   o_valid  result valid (DONE state)
//   o_ready  consumer accepts the result
//   o_y      result; mirrors the working register in every state
module shifter_serial #(
  parameter int N  = 32,
  parameter int SW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [1:0]    i_op,
  input  logic [N-1:0]  i_a,
  input  logic [SW-1:0] i_s,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [N-1:0]  o_y
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [1:0] OP_LL  = 2'b00;
  localparam logic [1:0] OP_RL  = 2'b01;
  localparam logic [1:0] OP_RA  = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam logic [SW-1:0] N_S   = SW'(N);
  localparam logic [SW-1:0] ONE_S = SW'(1);

  state_e        state_q, state_d;
  logic [1:0]    op_q,    op_d;
  logic [N-1:0]  y_q,     y_d;
  logic [SW-1:0] cnt_q,   cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LL;
      y_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          op_d  = i_op;
          y_d   = i_a;
          cnt_d = '0;
          // Priority: zero shift, then out-of-range (zero for every op,
          // pass-through included), then reserved op, then a real shift.
          if (i_s == '0) begin
            state_d = ST_DONE;
          end else if (i_s >= N_S) begin
            y_d     = '0;
            state_d = ST_DONE;
          end else if (i_op == OP_RSV) begin
            state_d = ST_DONE;
          end else begin
            cnt_d   = i_s;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        case (op_q)
          OP_LL:   y_d = {y_q[N-2:0], 1'b0};
          OP_RL:   y_d = {1'b0, y_q[N-1:1]};
          OP_RA:   y_d = {y_q[N-1], y_q[N-1:1]};
          default: y_d = y_q;
        endcase
        // cnt >= 1 on entry, so the decrement cannot wrap.
        cnt_d = cnt_q - ONE_S;
        if (cnt_q == ONE_S) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (o_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs come from registered state only; rst gating keeps
  // i_ready low for the whole reset window.
  assign i_ready = (state_q == ST_IDLE) && !rst;
  assign o_valid = (state_q == ST_DONE);
  assign o_y     = y_q;

endmodule
